// File: rtl/jtframe_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dump_pkg
//  Description : Shared constants for the multi-channel dump-window
//                controller: MODE encodings, register addresses, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtframe_dump_pkg;

    // Channel operating modes (MODE register, bits [1:0])
    localparam logic [1:0] c_MODE_OFF      = 2'd0;
    localparam logic [1:0] c_MODE_WINDOW   = 2'd1;
    localparam logic [1:0] c_MODE_AFTER_DL = 2'd2;
    localparam logic [1:0] c_MODE_PERIODIC = 2'd3;

    // Register addresses on the configuration port
    localparam logic [1:0] c_ADDR_START  = 2'd0;
    localparam logic [1:0] c_ADDR_LEN    = 2'd1;
    localparam logic [1:0] c_ADDR_PERIOD = 2'd2;
    localparam logic [1:0] c_ADDR_MODE   = 2'd3;

    // Per-channel FSM state encoding
    typedef logic [1:0] dump_state_t;
    localparam dump_state_t c_ST_IDLE  = 2'd0;
    localparam dump_state_t c_ST_ARMED = 2'd1;
    localparam dump_state_t c_ST_DUMP  = 2'd2;
    localparam dump_state_t c_ST_DONE  = 2'd3;

    // A channel may leave IDLE when enabled; AFTER_DL also waits for the
    // end of the ROM download.
    function automatic logic arm_ok(input logic [1:0] mode, input logic dl_done);
        return (mode != c_MODE_OFF) && ((mode != c_MODE_AFTER_DL) || dl_done);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_dump_ch.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dump_ch
//  Description : One dump channel: START/LEN/PERIOD/MODE registers, the
//                IDLE/ARMED/DUMP/DONE sequencer and the remaining-frame
//                counter that drives dump_on and its start/stop pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_dump_ch
    import jtframe_dump_pkg::*;
#(
    parameter int          FW   = 32,
    parameter int unsigned LEN0 = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,        // frame boundary strobe
    input  logic [FW-1:0] frame_nxt,   // value frame_cnt takes on this tick
    input  logic          dl_done,
    input  logic          cfg_we,      // write strobe already decoded for this channel
    input  logic [1:0]    cfg_addr,
    input  logic [FW-1:0] cfg_data,
    output logic          dump_on,
    output logic          dump_start,
    output logic          dump_stop
);

    logic [FW-1:0] r_start;
    logic [FW-1:0] r_len;
    logic [FW-1:0] r_period;
    logic [1:0]    r_mode;

    // Values captured at arm time so that writes during a dump only apply
    // to the following window.
    logic [FW-1:0] r_start_eff;
    logic [FW-1:0] r_len_eff;
    logic [FW-1:0] r_period_eff;
    logic [FW-1:0] r_rem;

    dump_state_t   r_state;
    logic          r_dump_on;
    logic          r_start_pulse;
    logic          r_stop_pulse;

    logic          w_mode_wr;
    logic          w_hit;

    assign w_mode_wr  = cfg_we && (cfg_addr == c_ADDR_MODE);
    assign w_hit      = tick && (frame_nxt == r_start_eff);

    assign dump_on    = r_dump_on;
    assign dump_start = r_start_pulse;
    assign dump_stop  = r_stop_pulse;

    // Configuration register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start  <= '0;
            r_len    <= FW'(LEN0);
            r_period <= '0;
            r_mode   <= c_MODE_OFF;
        end else if (cfg_we) begin
            case (cfg_addr)
                c_ADDR_START:  r_start  <= cfg_data;
                c_ADDR_LEN:    r_len    <= cfg_data;
                c_ADDR_PERIOD: r_period <= cfg_data;
                default:       r_mode   <= cfg_data[1:0];
            endcase
        end
    end

    // Channel sequencer; a MODE write always restarts from IDLE and wins
    // over a coincident frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_start_eff   <= '0;
            r_len_eff     <= FW'(LEN0);
            r_period_eff  <= '0;
            r_rem         <= '0;
            r_dump_on     <= 1'b0;
            r_start_pulse <= 1'b0;
            r_stop_pulse  <= 1'b0;
        end else begin
            r_start_pulse <= 1'b0;
            r_stop_pulse  <= 1'b0;
            if (w_mode_wr) begin
                r_state     <= c_ST_IDLE;
                r_start_eff <= r_start;
                if (r_dump_on) begin
                    r_dump_on    <= 1'b0;
                    r_stop_pulse <= 1'b1;
                end
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (arm_ok(r_mode, dl_done)) begin
                            r_state      <= c_ST_ARMED;
                            r_len_eff    <= r_len;
                            r_period_eff <= r_period;
                        end
                    end
                    c_ST_ARMED: begin
                        if (w_hit) begin
                            if (r_len_eff == '0) begin
                                // Zero-length window: consumed silently
                                r_state <= c_ST_DONE;
                            end else begin
                                r_state       <= c_ST_DUMP;
                                r_rem         <= r_len_eff;
                                r_dump_on     <= 1'b1;
                                r_start_pulse <= 1'b1;
                            end
                        end
                    end
                    c_ST_DUMP: begin
                        if (tick) begin
                            if (r_rem <= FW'(1)) begin
                                r_dump_on    <= 1'b0;
                                r_stop_pulse <= 1'b1;
                                if ((r_mode == c_MODE_PERIODIC) && (r_period_eff > r_len_eff)) begin
                                    // Next window PERIOD frames later; pick up
                                    // any LEN/PERIOD written meanwhile.
                                    r_state      <= c_ST_ARMED;
                                    r_start_eff  <= r_start_eff + r_period_eff;
                                    r_len_eff    <= r_len;
                                    r_period_eff <= r_period;
                                end else begin
                                    r_state <= c_ST_DONE;
                                end
                            end else begin
                                r_rem <= r_rem - FW'(1);
                            end
                        end
                    end
                    c_ST_DONE: begin
                        r_state <= c_ST_DONE;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtframe_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_dump_ctrl
//  Description : Multi-channel simulation dump-window controller. Counts
//                frames on VS falling edges, tracks the end of the ROM
//                download and drives per-channel dump enables and pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_dump_ctrl
    import jtframe_dump_pkg::*;
#(
    parameter int          CH   = 4,
    parameter int          FW   = 32,
    parameter int unsigned LEN0 = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 vs,
    input  logic                                 dwnld,
    input  logic                                 cfg_we,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                           cfg_addr,
    input  logic [FW-1:0]                        cfg_data,
    output logic [FW-1:0]                        frame_cnt,
    output logic                                 dl_done,
    output logic [CH-1:0]                        dump_on,
    output logic [CH-1:0]                        dump_start,
    output logic [CH-1:0]                        dump_stop
);

    localparam int c_CHW = (CH > 1) ? $clog2(CH) : 1;

    logic          r_vs_l;
    logic          r_tick;
    logic          r_dl_l;
    logic [FW-1:0] r_frame_cnt;
    logic          r_dl_done;

    logic          w_dl_fall;
    logic [FW-1:0] w_frame_nxt;
    logic [CH-1:0] w_ch_we;

    assign w_dl_fall   = r_dl_l & ~dwnld;
    // Frame number the channels compare against on a tick; the download
    // restart takes priority over the increment.
    assign w_frame_nxt = w_dl_fall ? '0 : (r_frame_cnt + FW'(1));

    assign frame_cnt   = r_frame_cnt;
    assign dl_done     = r_dl_done;

    // Registered VS falling-edge detector and download-flag history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_l <= 1'b0;
            r_tick <= 1'b0;
            r_dl_l <= 1'b0;
        end else begin
            r_vs_l <= vs;
            r_tick <= r_vs_l & ~vs;
            r_dl_l <= dwnld;
        end
    end

    // Frame counter and sticky download-finished flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_dl_done   <= 1'b0;
        end else begin
            if (w_dl_fall) begin
                r_frame_cnt <= '0;
                r_dl_done   <= 1'b1;
            end else if (r_tick) begin
                r_frame_cnt <= w_frame_nxt;
            end
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        assign w_ch_we[gi] = cfg_we && (cfg_ch == c_CHW'(gi));

        jtframe_dump_ch #(
            .FW   (FW),
            .LEN0 (LEN0)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (r_tick),
            .frame_nxt  (w_frame_nxt),
            .dl_done    (r_dl_done),
            .cfg_we     (w_ch_we[gi]),
            .cfg_addr   (cfg_addr),
            .cfg_data   (cfg_data),
            .dump_on    (dump_on[gi]),
            .dump_start (dump_start[gi]),
            .dump_stop  (dump_stop[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtframe_dump_ctrl
//  Description : Directed self-checking bench for jtframe_dump_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_dump_ctrl;
    import jtframe_dump_pkg::*;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        vs       = 1'b0;
    logic        dwnld    = 1'b0;
    logic        cfg_we   = 1'b0;
    logic [1:0]  cfg_ch   = 2'd0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [31:0] cfg_data = 32'd0;
    logic [31:0] frame_cnt;
    logic        dl_done;
    logic [3:0]  dump_on;
    logic [3:0]  dump_start;
    logic [3:0]  dump_stop;

    // Narrow instance used for the counter wrap check
    logic        cfg_we4   = 1'b0;
    logic [0:0]  cfg_ch4   = 1'b0;
    logic [3:0]  cfg_data4 = 4'd0;
    logic [3:0]  frame_cnt4;
    logic        dl_done4;
    logic [0:0]  dump_on4;
    logic [0:0]  dump_start4;
    logic [0:0]  dump_stop4;

    int checks = 0;
    int errors = 0;
    int start_cnt [4];
    int stop_cnt  [4];

    jtframe_dump_ctrl #(.CH(4), .FW(32), .LEN0(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vs         (vs),
        .dwnld      (dwnld),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .frame_cnt  (frame_cnt),
        .dl_done    (dl_done),
        .dump_on    (dump_on),
        .dump_start (dump_start),
        .dump_stop  (dump_stop)
    );

    jtframe_dump_ctrl #(.CH(1), .FW(4), .LEN0(1)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .vs         (vs),
        .dwnld      (dwnld),
        .cfg_we     (cfg_we4),
        .cfg_ch     (cfg_ch4),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data4),
        .frame_cnt  (frame_cnt4),
        .dl_done    (dl_done4),
        .dump_on    (dump_on4),
        .dump_start (dump_start4),
        .dump_stop  (dump_stop4)
    );

    always #5 clk = ~clk;

    // Pulse counters per channel
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dump_start[i] === 1'b1) start_cnt[i] = start_cnt[i] + 1;
            if (dump_stop[i]  === 1'b1) stop_cnt[i]  = stop_cnt[i] + 1;
        end
    end

    task automatic do_reset;
        @(posedge clk); #1;
        rst_n = 1'b0; vs = 1'b0; dwnld = 1'b0; cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_cnt[i] = 0;
            stop_cnt[i]  = 0;
        end
    endtask

    task automatic cfg_wr(input int ch, input int addr, input logic [31:0] data);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_ch = ch[1:0]; cfg_addr = addr[1:0]; cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // One VS pulse; returns at a falling clock edge once the tick has settled
    task automatic frame;
        @(posedge clk); #1 vs = 1'b1;
        repeat (3) @(posedge clk);
        #1 vs = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
        checks++; if (dl_done !== 1'b0) begin errors++; $display("FAIL reset_dl_done got %b exp 0", dl_done); end
        checks++; if (dump_on !== 4'd0) begin errors++; $display("FAIL reset_dump_on got %b exp 0000", dump_on); end
        checks++; if (dump_start !== 4'd0) begin errors++; $display("FAIL reset_dump_start got %b exp 0000", dump_start); end
        checks++; if (dump_stop !== 4'd0) begin errors++; $display("FAIL reset_dump_stop got %b exp 0000", dump_stop); end
    endtask

    task automatic test_window;
        logic exp_on;
        do_reset();
        cfg_wr(0, 0, 32'd5);
        cfg_wr(0, 1, 32'd3);
        cfg_wr(0, 3, 32'd1);
        for (int f = 1; f <= 10; f++) begin
            frame();
            exp_on = (f >= 5) && (f <= 7);
            checks++; if (dump_on[0] !== exp_on) begin errors++; $display("FAIL window_on frame %0d got %b exp %b", f, dump_on[0], exp_on); end
            checks++; if (frame_cnt !== 32'(f)) begin errors++; $display("FAIL window_frame_cnt got %0d exp %0d", frame_cnt, f); end
        end
        checks++; if (start_cnt[0] != 1) begin errors++; $display("FAIL window_starts got %0d exp 1", start_cnt[0]); end
        checks++; if (stop_cnt[0] != 1) begin errors++; $display("FAIL window_stops got %0d exp 1", stop_cnt[0]); end
    endtask

    task automatic test_after_dl;
        logic exp_on;
        do_reset();
        cfg_wr(1, 0, 32'd2);
        cfg_wr(1, 1, 32'd1);
        cfg_wr(1, 3, 32'd2);
        @(posedge clk); #1 dwnld = 1'b1;
        for (int f = 1; f <= 7; f++) begin
            frame();
            checks++; if (dump_on[1] !== 1'b0) begin errors++; $display("FAIL afterdl_early frame %0d got %b exp 0", f, dump_on[1]); end
        end
        @(posedge clk); #1 dwnld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL afterdl_frame_cnt got %0d exp 0", frame_cnt); end
        checks++; if (dl_done !== 1'b1) begin errors++; $display("FAIL afterdl_dl_done got %b exp 1", dl_done); end
        for (int f = 1; f <= 4; f++) begin
            frame();
            exp_on = (f == 2);
            checks++; if (dump_on[1] !== exp_on) begin errors++; $display("FAIL afterdl_on frame %0d got %b exp %b", f, dump_on[1], exp_on); end
        end
        checks++; if (start_cnt[1] != 1 || stop_cnt[1] != 1) begin errors++; $display("FAIL afterdl_pulses got %0d/%0d exp 1/1", start_cnt[1], stop_cnt[1]); end
    endtask

    task automatic test_periodic;
        logic exp_on;
        do_reset();
        cfg_wr(2, 0, 32'd4);
        cfg_wr(2, 2, 32'd10);
        cfg_wr(2, 1, 32'd2);
        cfg_wr(2, 3, 32'd3);
        for (int f = 1; f <= 30; f++) begin
            frame();
            exp_on = (f >= 4) && (((f - 4) % 10) < 2);
            checks++; if (dump_on[2] !== exp_on) begin errors++; $display("FAIL periodic_on frame %0d got %b exp %b", f, dump_on[2], exp_on); end
        end
        checks++; if (start_cnt[2] != 3) begin errors++; $display("FAIL periodic_starts got %0d exp 3", start_cnt[2]); end
        checks++; if (stop_cnt[2] != 3) begin errors++; $display("FAIL periodic_stops got %0d exp 3", stop_cnt[2]); end
    endtask

    task automatic test_len_zero;
        logic exp_on;
        do_reset();
        cfg_wr(3, 0, 32'd1);
        cfg_wr(3, 1, 32'd0);
        cfg_wr(3, 3, 32'd1);
        for (int f = 1; f <= 3; f++) begin
            frame();
            checks++; if (dump_on[3] !== 1'b0) begin errors++; $display("FAIL len0_on frame %0d got %b exp 0", f, dump_on[3]); end
        end
        checks++; if (dut.g_ch[3].u_ch.r_state !== c_ST_DONE) begin errors++; $display("FAIL len0_state got %0d exp %0d", dut.g_ch[3].u_ch.r_state, c_ST_DONE); end
        checks++; if (start_cnt[3] != 0 || stop_cnt[3] != 0) begin errors++; $display("FAIL len0_pulses got %0d/%0d exp 0/0", start_cnt[3], stop_cnt[3]); end
        // Periodic with PERIOD not larger than LEN: a single window
        cfg_wr(3, 0, 32'd5);
        cfg_wr(3, 1, 32'd2);
        cfg_wr(3, 2, 32'd2);
        cfg_wr(3, 3, 32'd3);
        for (int f = 4; f <= 10; f++) begin
            frame();
            exp_on = (f == 5) || (f == 6);
            checks++; if (dump_on[3] !== exp_on) begin errors++; $display("FAIL short_period_on frame %0d got %b exp %b", f, dump_on[3], exp_on); end
        end
        checks++; if (dut.g_ch[3].u_ch.r_state !== c_ST_DONE) begin errors++; $display("FAIL short_period_state got %0d exp %0d", dut.g_ch[3].u_ch.r_state, c_ST_DONE); end
        checks++; if (start_cnt[3] != 1 || stop_cnt[3] != 1) begin errors++; $display("FAIL short_period_pulses got %0d/%0d exp 1/1", start_cnt[3], stop_cnt[3]); end
    endtask

    task automatic test_mode_off;
        do_reset();
        cfg_wr(0, 0, 32'd3);
        cfg_wr(0, 1, 32'd10);
        cfg_wr(0, 3, 32'd1);
        cfg_wr(1, 0, 32'd3);
        cfg_wr(1, 1, 32'd10);
        cfg_wr(1, 3, 32'd1);
        for (int f = 1; f <= 6; f++) frame();
        checks++; if (dump_on[1:0] !== 2'b11) begin errors++; $display("FAIL modeoff_before got %b exp 11", dump_on[1:0]); end
        cfg_wr(0, 3, 32'd0);
        @(negedge clk);
        checks++; if (dump_on[0] !== 1'b0) begin errors++; $display("FAIL modeoff_on got %b exp 0", dump_on[0]); end
        checks++; if (dump_stop[0] !== 1'b1) begin errors++; $display("FAIL modeoff_stop got %b exp 1", dump_stop[0]); end
        checks++; if (dump_on[1] !== 1'b1) begin errors++; $display("FAIL modeoff_other got %b exp 1", dump_on[1]); end
        repeat (2) @(negedge clk);
        // Asynchronous reset while channel 1 is dumping
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dump_on !== 4'd0) begin errors++; $display("FAIL async_rst_on got %b exp 0000", dump_on); end
        checks++; if (dump_stop !== 4'd0) begin errors++; $display("FAIL async_rst_stop got %b exp 0000", dump_stop); end
        repeat (2) @(negedge clk);
        checks++; if (stop_cnt[1] != 0) begin errors++; $display("FAIL async_rst_pulses got %0d exp 0", stop_cnt[1]); end
        checks++; if (stop_cnt[0] != 1) begin errors++; $display("FAIL modeoff_pulses got %0d exp 1", stop_cnt[0]); end
        rst_n = 1'b1;
    endtask

    task automatic test_dl_tick;
        do_reset();
        @(posedge clk); #1 dwnld = 1'b1;
        for (int f = 1; f <= 9; f++) frame();
        checks++; if (frame_cnt !== 32'd9) begin errors++; $display("FAIL dltick_pre got %0d exp 9", frame_cnt); end
        // Release the download in the very cycle the registered tick is high
        @(posedge clk); #1 vs = 1'b1;
        repeat (3) @(posedge clk);
        #1 vs = 1'b0;
        @(posedge clk);
        #1 dwnld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL dltick_frame_cnt got %0d exp 0", frame_cnt); end
        checks++; if (dl_done !== 1'b1) begin errors++; $display("FAIL dltick_dl_done got %b exp 1", dl_done); end
    endtask

    task automatic test_wrap;
        do_reset();
        for (int f = 1; f <= 17; f++) frame();
        checks++; if (frame_cnt4 !== 4'd1) begin errors++; $display("FAIL wrap_fw4 got %0d exp 1", frame_cnt4); end
        checks++; if (frame_cnt !== 32'd17) begin errors++; $display("FAIL wrap_fw32 got %0d exp 17", frame_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start_cnt[i] = 0;
            stop_cnt[i]  = 0;
        end
        test_reset();
        test_window();
        test_after_dl();
        test_periodic();
        test_len_zero();
        test_mode_off();
        test_dl_tick();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtframe_dump_ctrl.md
Name: jtframe_dump_ctrl

Overview:
- Multi-channel simulation dump-window controller; the successor to the single-trigger frame dumper.
- Counts frames from VS falling edges and watches the ROM-download flag.
- Drives per-channel dump enables, plus start/stop pulses, for the test harness ($dumpon/$shm_probe wrappers).
- Sits beside the game top in mist/mister test benches; configured at time 0 or at run time through a register write port.

Parameters:
- CH, 4: number of independent dump channels (probe groups).
- FW, 32: frame counter and register width.
- LEN0, 1: reset value of each channel's LEN register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- vs  in  1  vertical sync, synchronous to clk; frame boundary is its falling edge
- dwnld  in  1  ROM download busy (the led signal); end of download is its falling edge
- cfg_we  in  1  register write strobe
- cfg_ch  in  $clog2(CH) (min 1)  channel select
- cfg_addr  in  2  0=START, 1=LEN, 2=PERIOD, 3=MODE
- cfg_data  in  FW  write data; MODE uses bits [1:0]
- frame_cnt  out  FW  current frame number
- dl_done  out  1  set once a download has finished
- dump_on  out  CH  per-channel dump enable
- dump_start  out  CH  one-cycle pulse when dump_on rises
- dump_stop  out  CH  one-cycle pulse when dump_on falls

Behaviour:
- Reset values: all outputs 0; START=0, LEN=LEN0, PERIOD=0, MODE=0 for every channel; all channel FSMs in IDLE.
- Frame tick:
  - vs_l is a registered copy of vs; tick = vs_l & ~vs (registered edge detect, one cycle late).
  - frame_cnt increments by 1 per tick and wraps at 2^FW-1 -> 0.
- Download end:
  - dl_fall = dl_l & ~dwnld.
  - On dl_fall: dl_done<=1 and frame_cnt<=0. dl_fall takes priority over a tick in the same cycle.
  - dl_done is sticky until reset.
- MODE encodings:
  - 0 OFF
  - 1 WINDOW: dump frames START..START+LEN-1
  - 2 AFTER_DL: as WINDOW, but armed only once dl_done=1
  - 3 PERIODIC: dump LEN frames starting at START, repeated every PERIOD frames
- Per-channel FSM states: IDLE, ARMED, DUMP, DONE. Transitions:
  - IDLE->ARMED when MODE!=0, and for MODE 2 also dl_done=1.
  - ARMED->DUMP on a tick where frame_cnt (post-increment value) == START. Set dump_on=1 and pulse dump_start in the same cycle.
  - Entering DUMP loads a LEN-wide remaining counter rem=LEN. Each tick in DUMP decrements rem; when rem reaches 0, dump_on=0 and dump_stop pulses.
  - Exit from DUMP: MODE 1/2 go to DONE. MODE 3 with PERIOD>LEN goes to ARMED with START_eff += PERIOD (wraps mod 2^FW); otherwise it goes to DONE.
  - LEN=0: the channel never enters DUMP; ARMED->DONE on the START tick, with no pulses.
  - DONE is terminal until MODE is rewritten.
- Config writes:
  - Registers update on the cycle after cfg_we.
  - START/LEN/PERIOD written during DUMP take effect only at the next arm. START_eff reloads from START on every MODE write.
  - MODE write to 0 from any state -> IDLE. If dump_on was 1, it clears on the next cycle and dump_stop pulses.
  - MODE write of non-zero -> IDLE, then re-arms per the rules above.
- Simultaneity:
  - A cfg write and a tick in the same cycle: the FSM evaluates the tick with the old registers.
  - Channels are independent; several may pulse in the same cycle.
- Reset mid-dump: all dump_on drop asynchronously with no dump_stop pulse; the harness treats a reset as an implicit stop.
- Latency: tick to dump_on is 1 clk after the vs falling edge is registered, i.e. 2 clks from the vs transition.

Decomposition:
- Shared package jtframe_dump_pkg holds:
  - MODE constants (OFF/WINDOW/AFTER_DL/PERIODIC)
  - FSM state typedef
  - register address constants
- One sub-module, jtframe_dump_ch: per-channel registers, FSM and rem counter, instantiated CH times in a generate loop.
- Top level holds the edge detectors, frame_cnt, dl_done and the cfg decode.

Test Plan:
- ch0 MODE=1, START=5, LEN=3; 10 vs pulses -> dump_on[0] rises on frame 5 tick, falls on frame 8 tick; one start and one stop pulse.
- ch1 MODE=2, START=2, LEN=1; dwnld high then low at frame 7 -> frame_cnt=0, dl_done=1; dump_on[1] is high for frame 2..3 after the download only.
- ch2 MODE=3, START=4, PERIOD=10, LEN=2 -> windows at frames 4-5, 14-15, 24-25; 3 start and 3 stop pulses by frame 30.
- ch3 MODE=1, LEN=0, START=1 -> dump_on never rises, FSM ends in DONE; separately MODE=3 with PERIOD=2, LEN=2 -> single window, then DONE.
- ch0 dumping at frame 6; write MODE=0 -> dump_on[0] low next cycle with a dump_stop pulse; assert rst_n=0 mid-dump on another channel -> dump_on cleared immediately, no pulse.
- dl_fall coincident with a tick at frame_cnt=9 -> frame_cnt=0 (not 10); FW=4 with 17 ticks -> frame_cnt wraps to 1.
